// File: rtl/placar_basquete_param_if.sv
`default_nettype none
// ============================================================================
// placar_basquete_param_if : button/switch inputs and display/buzzer outputs
// Rev 1.0
// ============================================================================
interface placar_basquete_param_if #(
  parameter int N_TEAMS   = 2,
  parameter int N_DIGITS  = 2,
  parameter int SCORE_MAX = 99
);
  localparam int W  = $clog2(SCORE_MAX + 1);
  localparam int TW = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1;
  localparam int ND = N_TEAMS * N_DIGITS;

  logic [2:0]           cBotoes;
  logic                 chaveNP;
  logic [TW-1:0]        chaveTime;
  logic                 buzzer;
  logic                 led;
  logic [6:0]           display;
  logic [ND-1:0]        escolhaDisplay;
  logic [N_TEAMS*W-1:0] placar;

  modport master (
    output cBotoes, chaveNP, chaveTime,
    input  buzzer, led, display, escolhaDisplay, placar
  );

  modport slave (
    input  cBotoes, chaveNP, chaveTime,
    output buzzer, led, display, escolhaDisplay, placar
  );
endinterface
`default_nettype wire

// File: rtl/placar_basquete_param.sv
`default_nettype none
// ============================================================================
// placar_basquete_param : N-team clamped scoreboard with BCD 7-segment scan
// Rev 1.0
// ============================================================================
module placar_basquete_param #(
  parameter int N_TEAMS     = 2,
  parameter int N_DIGITS    = 2,
  parameter int SCORE_MAX   = 99,
  parameter int SCAN_DIV    = 50000,
  parameter int BUZZ_CYCLES = 25000000
) (
  input wire clock,
  input wire reset,
  placar_basquete_param_if.slave bus
);
  localparam int W  = $clog2(SCORE_MAX + 1);
  localparam int TW = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1;
  localparam int ND = N_TEAMS * N_DIGITS;
  localparam int WE = W + 2;
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam int CW = $clog2(W + 1);
  localparam int BD = 4 * N_DIGITS;

  logic [2:0]    prev;
  logic [W-1:0]  score [N_TEAMS];
  logic          led_r;
  logic [BW-1:0] buzz_cnt;

  logic [2:0]    edges;
  logic [WE-1:0] pts;
  logic [WE-1:0] cur;
  logic [WE-1:0] sum;
  logic          valid;

  // Highest-value button wins when several rise together.
  always_comb begin
    edges = bus.cBotoes & ~prev;
    pts   = edges[2] ? WE'(3) : edges[1] ? WE'(2) : edges[0] ? WE'(1) : '0;
    valid = (edges != 3'b000) && (int'(bus.chaveTime) < N_TEAMS);
    cur   = valid ? WE'(score[bus.chaveTime]) : '0;
    sum   = cur + pts;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev     <= 3'b111;
      led_r    <= 1'b0;
      buzz_cnt <= '0;
      for (int i = 0; i < N_TEAMS; i++) score[i] <= '0;
    end else begin
      prev <= bus.cBotoes;
      if (buzz_cnt != '0) buzz_cnt <= buzz_cnt - 1'b1;
      if (valid) begin
        if (bus.chaveNP) begin
          if (sum > WE'(SCORE_MAX)) begin
            score[bus.chaveTime] <= W'(SCORE_MAX);
            led_r                <= 1'b1;
            buzz_cnt             <= BW'(BUZZ_CYCLES);
          end else begin
            score[bus.chaveTime] <= W'(sum);
            led_r                <= 1'b0;
          end
        end else begin
          if (pts > cur) begin
            score[bus.chaveTime] <= '0;
            led_r                <= 1'b1;
          end else begin
            score[bus.chaveTime] <= W'(cur - pts);
            led_r                <= 1'b0;
          end
        end
      end
    end
  end

  typedef enum logic [1:0] {CV_LOAD = 2'd0, CV_SHIFT = 2'd1, CV_STORE = 2'd2} cv_state_t;
  cv_state_t       state, state_nx;
  logic [TW-1:0]   cv_idx;
  logic [W-1:0]    cv_bin;
  logic [BD-1:0]   cv_acc;
  logic [BD-1:0]   cv_adj;
  logic [BD+W-1:0] cv_shift;
  logic [CW-1:0]   cv_cnt;
  logic [BD-1:0]   bcd [N_TEAMS];

  always_ff @(posedge clock) begin
    if (reset) state <= CV_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cv_adj   = cv_acc;
    for (int j = 0; j < N_DIGITS; j++)
      if (cv_acc[4*j +: 4] >= 4'd5) cv_adj[4*j +: 4] = cv_acc[4*j +: 4] + 4'd3;
    cv_shift = {cv_adj, cv_bin} << 1;
    case (state)
      CV_LOAD:  state_nx = CV_SHIFT;
      CV_SHIFT: if (cv_cnt == CW'(W - 1)) state_nx = CV_STORE;
      CV_STORE: state_nx = CV_LOAD;
      default:  state_nx = CV_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cv_idx <= '0;
      cv_bin <= '0;
      cv_acc <= '0;
      cv_cnt <= '0;
      for (int i = 0; i < N_TEAMS; i++) bcd[i] <= '0;
    end else begin
      case (state)
        CV_LOAD: begin
          cv_bin <= score[cv_idx];
          cv_acc <= '0;
          cv_cnt <= '0;
        end
        CV_SHIFT: begin
          {cv_acc, cv_bin} <= cv_shift;
          cv_cnt           <= cv_cnt + 1'b1;
        end
        CV_STORE: begin
          bcd[cv_idx] <= cv_acc;
          cv_idx      <= (cv_idx == TW'(N_TEAMS - 1)) ? '0 : cv_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [DW-1:0] div;
  logic [KW-1:0] k;

  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      k   <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      k   <= (k == KW'(ND - 1)) ? '0 : k + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  int         disp_team;
  int         disp_dig;
  logic       blank;
  logic [3:0] nib;
  logic [6:0] seg;

  // Upper digits blank while they and every digit above them are zero.
  always_comb begin
    disp_team = int'(k) / N_DIGITS;
    disp_dig  = int'(k) % N_DIGITS;
    nib       = bcd[disp_team][4*disp_dig +: 4];
    blank     = (disp_dig != 0);
    for (int j = 1; j < N_DIGITS; j++)
      if (j >= disp_dig && bcd[disp_team][4*j +: 4] != 4'd0) blank = 1'b0;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
    if (blank) seg = 7'h7F;
  end

  assign bus.display        = seg;
  assign bus.escolhaDisplay = ~(ND'(1) << k);
  assign bus.buzzer         = (buzz_cnt != '0);
  assign bus.led            = led_r;

  for (genvar i = 0; i < N_TEAMS; i++) begin : g_placar
    assign bus.placar[i*W +: W] = score[i];
  end
endmodule
`default_nettype wire

// File: tb/tb_placar_basquete_param.sv
`default_nettype none
// ============================================================================
// tb_placar_basquete_param : scoreboard-driven bench for placar_basquete_param
// Rev 1.0
// ============================================================================
module tb_placar_basquete_param;
  localparam int SCORE_MAX = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  placar_basquete_param_if #(.N_TEAMS(2), .N_DIGITS(2), .SCORE_MAX(SCORE_MAX)) bus ();

  placar_basquete_param #(
    .N_TEAMS(2), .N_DIGITS(2), .SCORE_MAX(SCORE_MAX), .SCAN_DIV(4), .BUZZ_CYCLES(8)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [13:0] placar;
    logic        led;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m [2];
  logic mled;
  exp_t sb [$];
  exp_t e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scoring rules; every button event pushes the expected state.
  function automatic void model_event(input logic [2:0] b, input logic add, input int team);
    int pts;
    int s;
    pts = b[2] ? 3 : (b[1] ? 2 : (b[0] ? 1 : 0));
    if (pts != 0 && team < 2) begin
      if (add) begin
        s = m[team] + pts;
        if (s > SCORE_MAX) begin m[team] = SCORE_MAX; mled = 1'b1; end
        else begin m[team] = s; mled = 1'b0; end
      end else begin
        if (pts > m[team]) begin m[team] = 0; mled = 1'b1; end
        else begin m[team] = m[team] - pts; mled = 1'b0; end
      end
    end
    sb.push_back('{placar: {7'(m[1]), 7'(m[0])}, led: mled});
  endfunction

  function automatic void model_reset();
    m[0] = 0;
    m[1] = 0;
    mled = 1'b0;
    sb.delete();
  endfunction

  task automatic press(input logic [2:0] b);
    bus.cBotoes = b;
    model_event(b, bus.chaveNP, int'(bus.chaveTime));
    tick();
    bus.cBotoes = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cBotoes = 3'b000;
    bus.chaveNP = 1'b1;
    bus.chaveTime = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.placar !== 14'd0) $display("FAIL reset_placar: got %h want 0", bus.placar); else n_pass++;
    n_checks++; if (bus.led !== 1'b0) $display("FAIL reset_led: got %b want 0", bus.led); else n_pass++;
    n_checks++; if (bus.buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b want 0", bus.buzzer); else n_pass++;
    n_checks++; if (bus.escolhaDisplay !== 4'b1110) $display("FAIL reset_sel: got %b want 1110", bus.escolhaDisplay); else n_pass++;
    n_checks++; if (bus.display !== 7'b1000000) $display("FAIL reset_disp: got %b want 1000000", bus.display); else n_pass++;
    rst = 1'b0;
    model_reset();
    tick();
    tick();
  endtask

  task automatic test_add();
    bit seen0;
    bit seen1;
    seen0 = 0;
    seen1 = 0;
    bus.chaveNP = 1'b1;
    bus.chaveTime = 1'b0;
    bus.cBotoes = 3'b010;
    model_event(3'b010, 1'b1, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL add2_placar: got %h want %h", bus.placar, e.placar); else n_pass++;
    n_checks++; if (bus.led !== e.led) $display("FAIL add2_led: got %b want %b", bus.led, e.led); else n_pass++;
    bus.cBotoes = 3'b000;
    for (int i = 0; i < 48 && !(seen0 && seen1); i++) begin
      if (bus.escolhaDisplay == 4'b1110 && bus.display == 7'b0100100) seen0 = 1;
      if (bus.escolhaDisplay == 4'b1101 && bus.display == 7'h7F) seen1 = 1;
      tick();
    end
    n_checks++; if (!seen0) $display("FAIL add2_slot0: got no 0100100 on slot0 want 0100100"); else n_pass++;
    n_checks++; if (!seen1) $display("FAIL add2_slot1: got no blank on slot1 want 1111111"); else n_pass++;
  endtask

  task automatic test_clamp_add();
    int hi;
    for (int i = 0; i < 32; i++) begin
      press(3'b100);
      e = sb.pop_front();
      n_checks++; if (bus.placar !== e.placar || bus.led !== e.led)
        $display("FAIL climb_%0d: got %h/%b want %h/%b", i, bus.placar, bus.led, e.placar, e.led); else n_pass++;
    end
    bus.cBotoes = 3'b100;
    model_event(3'b100, 1'b1, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL clamp_placar: got %h want %h", bus.placar, e.placar); else n_pass++;
    n_checks++; if (bus.led !== 1'b1) $display("FAIL clamp_led: got %b want 1", bus.led); else n_pass++;
    hi = 0;
    while (bus.buzzer === 1'b1 && hi < 20) begin
      hi++;
      bus.cBotoes = 3'b000;
      tick();
    end
    n_checks++; if (hi != 8) $display("FAIL buzz_len: got %0d want 8", hi); else n_pass++;

    bus.cBotoes = 3'b100;
    model_event(3'b100, 1'b1, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL clamp2_placar: got %h want %h", bus.placar, e.placar); else n_pass++;
    bus.cBotoes = 3'b000;
    tick();
    tick();
    tick();
    bus.cBotoes = 3'b001;
    model_event(3'b001, 1'b1, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar || bus.led !== e.led)
      $display("FAIL retrig_state: got %h/%b want %h/%b", bus.placar, bus.led, e.placar, e.led); else n_pass++;
    hi = 0;
    while (bus.buzzer === 1'b1 && hi < 20) begin
      hi++;
      bus.cBotoes = 3'b000;
      tick();
    end
    n_checks++; if (hi != 8) $display("FAIL retrig_len: got %0d want 8", hi); else n_pass++;
  endtask

  task automatic test_reset_mid();
    press(3'b100);
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL pre_rst_placar: got %h want %h", bus.placar, e.placar); else n_pass++;
    bus.cBotoes = 3'b001;
    model_event(3'b001, 1'b1, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.buzzer !== 1'b1) $display("FAIL pre_rst_buzz: got %b want 1", bus.buzzer); else n_pass++;
    rst = 1'b1;
    model_reset();
    tick();
    n_checks++; if (bus.placar !== 14'd0) $display("FAIL mid_rst_placar: got %h want 0", bus.placar); else n_pass++;
    n_checks++; if (bus.led !== 1'b0) $display("FAIL mid_rst_led: got %b want 0", bus.led); else n_pass++;
    n_checks++; if (bus.buzzer !== 1'b0) $display("FAIL mid_rst_buzz: got %b want 0", bus.buzzer); else n_pass++;
    n_checks++; if (bus.escolhaDisplay !== 4'b1110) $display("FAIL mid_rst_sel: got %b want 1110", bus.escolhaDisplay); else n_pass++;
    n_checks++; if (bus.display !== 7'b1000000) $display("FAIL mid_rst_disp: got %b want 1000000", bus.display); else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (bus.placar !== 14'd0) $display("FAIL held_thru_rst: got %h want 0", bus.placar); else n_pass++;
    bus.cBotoes = 3'b000;
    tick();
    press(3'b001);
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar || bus.led !== e.led)
      $display("FAIL repress: got %h/%b want %h/%b", bus.placar, bus.led, e.placar, e.led); else n_pass++;
  endtask

  task automatic test_subtract();
    bus.chaveNP = 1'b0;
    bus.cBotoes = 3'b100;
    model_event(3'b100, 1'b0, 0);
    tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL sub_placar: got %h want %h", bus.placar, e.placar); else n_pass++;
    n_checks++; if (bus.led !== 1'b1) $display("FAIL sub_led: got %b want 1", bus.led); else n_pass++;
    n_checks++; if (bus.buzzer !== 1'b0) $display("FAIL sub_buzz: got %b want 0", bus.buzzer); else n_pass++;
    bus.cBotoes = 3'b000;
    tick();
    bus.chaveNP = 1'b1;
    press(3'b001);
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar || bus.led !== 1'b0)
      $display("FAIL sub_then_add: got %h/%b want %h/0", bus.placar, bus.led, e.placar); else n_pass++;
  endtask

  task automatic test_edges_and_team();
    press(3'b101);
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL priority: got %h want %h", bus.placar, e.placar); else n_pass++;
    bus.cBotoes = 3'b010;
    model_event(3'b010, 1'b1, 0);
    for (int i = 0; i < 10; i++) tick();
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL held_once: got %h want %h", bus.placar, e.placar); else n_pass++;
    bus.cBotoes = 3'b000;
    tick();
    bus.chaveTime = 1'b1;
    press(3'b010);
    e = sb.pop_front();
    n_checks++; if (bus.placar !== e.placar) $display("FAIL team1: got %h want %h", bus.placar, e.placar); else n_pass++;
    bus.chaveTime = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] seq [5];
    logic [3:0] prev_sel;
    bit         synced;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;
    synced = 0;
    for (int i = 0; i < 40 && !synced; i++) begin
      prev_sel = bus.escolhaDisplay;
      tick();
      if (bus.escolhaDisplay == 4'b1110 && prev_sel != 4'b1110) synced = 1;
    end
    n_checks++; if (!synced) $display("FAIL scan_sync: got no slot0 entry want 1110"); else n_pass++;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        n_checks++; if (bus.escolhaDisplay !== seq[s])
          $display("FAIL scan_%0d_%0d: got %b want %b", s, c, bus.escolhaDisplay, seq[s]); else n_pass++;
        tick();
      end
    end
  endtask

  initial begin
    bus.cBotoes = 3'b000;
    bus.chaveNP = 1'b1;
    bus.chaveTime = 1'b0;
    model_reset();
    test_reset();
    test_add();
    test_clamp_add();
    test_reset_mid();
    test_subtract();
    test_edges_and_team();
    test_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
